// File: rtl/scmp_bus_if.sv
//==============================================================================
// Module  : scmp_bus_if
// Purpose : SC/MP-style core bus bridge: latches ADS address/flags, issues a
//           level memory request per strobe, stretches the core with cpu_hold
//           until ack or timeout. Optional macro: SCMP_BUSIF_WAIT_EN (cfg_wait).
// Rev     : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module scmp_bus_if #(
  parameter logic [7:0]  RDATA_IDLE = 8'hFF,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_d_o,
  input  logic        cpu_ads_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  output logic [7:0]  cpu_d_i,
  output logic        cpu_hold,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  cycle_flags,
  output logic        halt,
  output logic        bus_err
`ifdef SCMP_BUSIF_WAIT_EN
  ,
  input  logic [2:0]  cfg_wait
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Last counter value before abort: mem_req stays up exactly TIMEOUT cycles.
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_mem_addr, w_mem_addr_nxt;
  logic [7:0]  r_mem_wdata, w_mem_wdata_nxt;
  logic        r_mem_we, w_mem_we_nxt;
  logic        r_mem_req, w_mem_req_nxt;
  logic        r_cpu_hold, w_cpu_hold_nxt;
  logic [7:0]  r_cpu_d_i, w_cpu_d_i_nxt;
  logic [3:0]  r_flags, w_flags_nxt;
  logic        r_halt, w_halt_nxt;
  logic        r_bus_err, w_bus_err_nxt;
  logic [7:0]  r_to_cnt, w_to_cnt_nxt;
  logic [2:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic [2:0]  w_wait;

`ifdef SCMP_BUSIF_WAIT_EN
  assign w_wait = cfg_wait;
`else
  assign w_wait = 3'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mem_addr  <= 16'h0000;
      r_mem_wdata <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_cpu_d_i   <= RDATA_IDLE;
      r_flags     <= 4'h0;
      r_halt      <= 1'b0;
      r_bus_err   <= 1'b0;
      r_to_cnt    <= 8'h00;
      r_wait_cnt  <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_cpu_hold  <= w_cpu_hold_nxt;
      r_cpu_d_i   <= w_cpu_d_i_nxt;
      r_flags     <= w_flags_nxt;
      r_halt      <= w_halt_nxt;
      r_bus_err   <= w_bus_err_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_we_nxt    = r_mem_we;
    w_mem_req_nxt   = r_mem_req;
    w_cpu_hold_nxt  = r_cpu_hold;
    w_cpu_d_i_nxt   = r_cpu_d_i;
    w_flags_nxt     = r_flags;
    w_halt_nxt      = 1'b0;
    w_bus_err_nxt   = 1'b0;
    w_to_cnt_nxt    = r_to_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;

    case (r_state)
      S_IDLE, S_ADDR, S_DONE: begin
        if (!cpu_ads_n) begin
          w_mem_addr_nxt = {cpu_d_o[3:0], cpu_addr};
          w_flags_nxt    = cpu_d_o[7:4];
          w_halt_nxt     = cpu_d_o[7];
          w_cpu_hold_nxt = 1'b0;
          w_state_nxt    = S_ADDR;
        end else if (r_state == S_ADDR && (!cpu_rd_n || !cpu_wr_n)) begin
          // A simultaneous read+write strobe is resolved as a flagged write.
          if (!cpu_wr_n) begin
            w_mem_wdata_nxt = cpu_d_o;
          end
          w_mem_we_nxt   = !cpu_wr_n;
          w_bus_err_nxt  = !cpu_rd_n && !cpu_wr_n;
          w_mem_req_nxt  = 1'b1;
          w_cpu_hold_nxt = 1'b1;
          w_to_cnt_nxt   = 8'h00;
          w_state_nxt    = S_ACCESS;
        end else if (r_state == S_DONE && cpu_rd_n && cpu_wr_n) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_ACCESS: begin
        if (mem_ack) begin
          if (!r_mem_we) begin
            w_cpu_d_i_nxt = mem_rdata;
          end
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          if (w_wait != 3'd0) begin
            w_wait_cnt_nxt = w_wait - 3'd1;
            w_state_nxt    = S_WAIT;
          end else begin
            w_cpu_hold_nxt = 1'b0;
            w_state_nxt    = S_DONE;
          end
        end else if (r_to_cnt == C_TO_LAST) begin
          if (!r_mem_we) begin
            w_cpu_d_i_nxt = RDATA_IDLE;
          end
          w_mem_req_nxt  = 1'b0;
          w_mem_we_nxt   = 1'b0;
          w_bus_err_nxt  = 1'b1;
          w_cpu_hold_nxt = 1'b0;
          w_state_nxt    = S_DONE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 8'd1;
        end
      end

      S_WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_cpu_hold_nxt = 1'b0;
          w_state_nxt    = S_DONE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 3'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cpu_d_i     = r_cpu_d_i;
  assign cpu_hold    = r_cpu_hold;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we;
  assign mem_req     = r_mem_req;
  assign cycle_flags = r_flags;
  assign halt        = r_halt;
  assign bus_err     = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_scmp_bus_if.sv
//==============================================================================
// Module  : tb_scmp_bus_if
// Purpose : Directed self-checking bench for scmp_bus_if.
// Rev     : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_scmp_bus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_d_o;
  logic        cpu_ads_n, cpu_rd_n, cpu_wr_n;
  logic [7:0]  cpu_d_i;
  logic        cpu_hold;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_req;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [3:0]  cycle_flags;
  logic        halt, bus_err;
`ifdef SCMP_BUSIF_WAIT_EN
  logic [2:0]  cfg_wait;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scmp_bus_if #(.RDATA_IDLE(8'hFF), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_d_o(cpu_d_o),
    .cpu_ads_n(cpu_ads_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_d_i(cpu_d_i), .cpu_hold(cpu_hold),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cycle_flags(cycle_flags), .halt(halt), .bus_err(bus_err)
`ifdef SCMP_BUSIF_WAIT_EN
    , .cfg_wait(cfg_wait)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_addr = 12'h000; cpu_d_o = 8'h00;
    cpu_ads_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    mem_rdata = 8'h00; mem_ack = 1'b0;
`ifdef SCMP_BUSIF_WAIT_EN
    cfg_wait = 3'd0;
`endif
    tick(); tick();
    checks++;
    if ({mem_req, mem_we, cpu_hold, halt, bus_err} !== 5'b00000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, cpu_hold, halt, bus_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, cycle_flags} !== 28'h0) begin
      failures++; $display("FAIL reset_regs got=%h exp=0000000", {mem_addr, mem_wdata, cycle_flags});
    end
    checks++;
    if (cpu_d_i !== 8'hFF) begin
      failures++; $display("FAIL reset_d_i got=%h exp=ff", cpu_d_i);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ads();
    cpu_ads_n = 1'b0; cpu_addr = 12'h345; cpu_d_o = 8'h5A;
    tick();
    cpu_ads_n = 1'b1;
    checks++;
    if ({mem_addr, cycle_flags, halt} !== {16'hA345, 4'h5, 1'b0}) begin
      failures++; $display("FAIL ads_latch got=%h/%h/%b exp=a345/5/0", mem_addr, cycle_flags, halt);
    end
    // Second ADS while in ADDR re-latches without starting an access.
    cpu_ads_n = 1'b0; cpu_addr = 12'h001; cpu_d_o = 8'h12;
    tick();
    cpu_ads_n = 1'b1;
    checks++;
    if ({mem_addr, cycle_flags, mem_req} !== {16'h2001, 4'h1, 1'b0}) begin
      failures++; $display("FAIL ads_relatch got=%h/%h/%b exp=2001/1/0", mem_addr, cycle_flags, mem_req);
    end
    cpu_ads_n = 1'b0; cpu_addr = 12'h345; cpu_d_o = 8'h5A;
    tick();
    cpu_ads_n = 1'b1;
  endtask

  task automatic test_read();
    cpu_rd_n = 1'b0;
    tick();
    checks++;
    if ({mem_req, mem_we, cpu_hold} !== 3'b101) begin
      failures++; $display("FAIL read_req got=%b exp=101", {mem_req, mem_we, cpu_hold});
    end
    tick(); tick();
    checks++;
    if ({mem_req, cpu_hold, mem_addr} !== {2'b11, 16'hA345}) begin
      failures++; $display("FAIL read_hold got=%b/%h exp=11/a345", {mem_req, cpu_hold}, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    checks++;
    if ({mem_req, cpu_hold, cpu_d_i} !== {2'b00, 8'hC3}) begin
      failures++; $display("FAIL read_done got=%b/%h exp=00/c3", {mem_req, cpu_hold}, cpu_d_i);
    end
    cpu_rd_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, cpu_d_i} !== {1'b0, 8'hC3}) begin
      failures++; $display("FAIL stray_ack got=%b/%h exp=0/c3", mem_req, cpu_d_i);
    end
  endtask

  task automatic test_write_timeout();
    bit held = 1'b1;
    cpu_ads_n = 1'b0; cpu_addr = 12'h012; cpu_d_o = 8'h01;
    tick();
    cpu_ads_n = 1'b1; cpu_wr_n = 1'b0; cpu_d_o = 8'h77;
    tick();
    checks++;
    if ({mem_req, mem_we, cpu_hold, bus_err, mem_wdata, mem_addr} !== {4'b1110, 8'h77, 16'h1012}) begin
      failures++; $display("FAIL write_req got=%b/%h/%h exp=1110/77/1012",
                           {mem_req, mem_we, cpu_hold, bus_err}, mem_wdata, mem_addr);
    end
    for (int i = 0; i < 14; i++) begin
      tick();
      if (!mem_req || bus_err) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      failures++; $display("FAIL timeout_early got=0 exp=1 (mem_req dropped before 15 cycles)");
    end
    tick();
    checks++;
    if ({mem_req, bus_err, cpu_hold, cpu_d_i} !== {3'b010, 8'hC3}) begin
      failures++; $display("FAIL timeout_abort got=%b/%h exp=010/c3", {mem_req, bus_err, cpu_hold}, cpu_d_i);
    end
    tick();
    checks++;
    if (bus_err !== 1'b0) begin
      failures++; $display("FAIL timeout_pulse got=%b exp=0", bus_err);
    end
    cpu_wr_n = 1'b1;
    tick();
    // Back in IDLE a bare read strobe must not start an access.
    cpu_rd_n = 1'b0;
    tick(); tick();
    cpu_rd_n = 1'b1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL idle_no_access got=%b exp=0", mem_req);
    end
  endtask

  task automatic test_halt();
    cpu_ads_n = 1'b0; cpu_addr = 12'hFFF; cpu_d_o = 8'h83;
    tick();
    cpu_ads_n = 1'b1;
    checks++;
    if ({halt, mem_addr, cycle_flags} !== {1'b1, 16'h3FFF, 4'h8}) begin
      failures++; $display("FAIL halt_set got=%b/%h/%h exp=1/3fff/8", halt, mem_addr, cycle_flags);
    end
    tick();
    checks++;
    if (halt !== 1'b0) begin
      failures++; $display("FAIL halt_pulse got=%b exp=0", halt);
    end
  endtask

  task automatic test_conflict();
    cpu_rd_n = 1'b0; cpu_wr_n = 1'b0; cpu_d_o = 8'h3C;
    tick();
    checks++;
    if ({mem_req, mem_we, bus_err, mem_wdata} !== {3'b111, 8'h3C}) begin
      failures++; $display("FAIL conflict got=%b/%h exp=111/3c", {mem_req, mem_we, bus_err}, mem_wdata);
    end
    tick();
    checks++;
    if ({mem_req, bus_err} !== 2'b10) begin
      failures++; $display("FAIL conflict_pulse got=%b exp=10", {mem_req, bus_err});
    end
    mem_ack = 1'b1; mem_rdata = 8'h55;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_req, cpu_hold, cpu_d_i} !== {2'b00, 8'hC3}) begin
      failures++; $display("FAIL conflict_done got=%b/%h exp=00/c3", {mem_req, cpu_hold}, cpu_d_i);
    end
    cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_access();
    cpu_ads_n = 1'b0; cpu_addr = 12'h0AB; cpu_d_o = 8'h04;
    tick();
    cpu_ads_n = 1'b1; cpu_rd_n = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, cpu_hold, cpu_d_i} !== {2'b00, 8'hFF}) begin
      failures++; $display("FAIL async_reset got=%b/%h exp=00/ff", {mem_req, cpu_hold}, cpu_d_i);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL no_resume got=%b exp=0", mem_req);
    end
    cpu_rd_n = 1'b1;
    tick();
  endtask

`ifdef SCMP_BUSIF_WAIT_EN
  task automatic test_wait();
    bit hold_ok = 1'b1;
    cfg_wait = 3'd3;
    cpu_ads_n = 1'b0; cpu_addr = 12'h100; cpu_d_o = 8'h00;
    tick();
    cpu_ads_n = 1'b1; cpu_rd_n = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h4E;
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!cpu_hold) hold_ok = 1'b0;
      if (i < 2) tick();
    end
    tick();
    checks++;
    if ({hold_ok, cpu_hold, cpu_d_i} !== {2'b10, 8'h4E}) begin
      failures++; $display("FAIL wait_hold got=%b/%h exp=10/4e", {hold_ok, cpu_hold}, cpu_d_i);
    end
    cpu_rd_n = 1'b1; cfg_wait = 3'd0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_ads();
    test_read();
    test_write_timeout();
    test_halt();
    test_conflict();
`ifdef SCMP_BUSIF_WAIT_EN
    test_wait();
`endif
    test_reset_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scmp_bus_if.md
SCMP_BUS_IF -- requirements
Module: scmp_bus_if

Interface
REQ-001 SHALL have parameter RDATA_IDLE, default 8'hFF, value on cpu_d_i when no read data is held.
REQ-002 SHALL have parameter TIMEOUT, default 15, number of mem_req cycles without mem_ack before abort (range 1..255).
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cpu_addr  in  12  low address bits from core.
REQ-006 cpu_d_o  in  8  core data out: {H,D,I,R,A[15:12]} during address phase, write data during write strobe.
REQ-007 cpu_ads_n, cpu_rd_n, cpu_wr_n  in  1 each  core bus strobes, active-low.
REQ-008 cpu_d_i  out  8  registered read data to core.
REQ-009 cpu_hold  out  1  active-high stretch request to core.
REQ-010 mem_addr  out  16  latched full address.
REQ-011 mem_wdata  out  8; mem_we  out  1; mem_req  out  1  memory request, level, held until acknowledged.
REQ-012 mem_rdata  in  8; mem_ack  in  1  one-cycle completion pulse.
REQ-013 cycle_flags  out  4  latched {H,D,I,R}; halt  out  1  one-cycle pulse; bus_err  out  1  one-cycle pulse.
REQ-014 cfg_wait  in  3  extra wait cycles, present only with SCMP_BUSIF_WAIT_EN.

Function
REQ-015 SHALL implement states IDLE, ADDR, ACCESS, WAIT, DONE.
REQ-016 IDLE/ADDR/DONE, cpu_ads_n=0 sampled: mem_addr <= {cpu_d_o[3:0],cpu_addr}, cycle_flags <= cpu_d_o[7:4], go ADDR; halt pulses next cycle if cpu_d_o[7]=1.
REQ-017 ADDR, cpu_ads_n=0 again: re-latch address/flags, stay ADDR, no memory access issued.
REQ-018 ADDR, cpu_rd_n=0: next cycle mem_req=1, mem_we=0, cpu_hold=1, go ACCESS.
REQ-019 ADDR, cpu_wr_n=0: mem_wdata <= cpu_d_o, next cycle mem_req=1, mem_we=1, cpu_hold=1, go ACCESS.
REQ-020 ADDR, cpu_rd_n=0 and cpu_wr_n=0 together: perform write, pulse bus_err.
REQ-021 ACCESS, mem_ack=1: read captures mem_rdata into cpu_d_i; mem_req, mem_we drop next cycle; go WAIT if wait count >0 else DONE.
REQ-022 ACCESS: mem_req held constant; mem_addr, mem_wdata, mem_we stable until exit.
REQ-023 ACCESS, TIMEOUT consecutive cycles without mem_ack: deassert mem_req, pulse bus_err, cpu_d_i <= RDATA_IDLE (read only), go DONE.
REQ-024 mem_ack outside ACCESS SHALL be ignored.
REQ-025 WAIT: down-count wait cycles, go DONE at zero; cpu_hold stays 1.
REQ-026 DONE: cpu_hold=0; return IDLE when cpu_rd_n=1 and cpu_wr_n=1; cpu_d_i holds read data until next read captures.
REQ-027 Latency: strobe sampled to mem_req =1 cycle; mem_ack to cpu_hold low =1+wait cycles.
REQ-028 Timeout counter 8 bits, cleared on ACCESS entry, no wrap.

Reset
REQ-029 rst_n low: state IDLE, mem_req=0, mem_we=0, cpu_hold=0, halt=0, bus_err=0, mem_addr=0, mem_wdata=0, cycle_flags=0, cpu_d_i=RDATA_IDLE, counters 0.
REQ-030 Reset mid-ACCESS SHALL drop mem_req asynchronously; no access resumes after release.

Configuration
REQ-031 Macro SCMP_BUSIF_WAIT_EN defined: cfg_wait port present, sampled at ACCESS exit, WAIT inserts cfg_wait cycles (0 = skip WAIT).
REQ-032 Macro undefined: no cfg_wait port, WAIT state never entered, ACCESS exits directly to DONE.

Verification
REQ-033 ADS with cpu_addr=12'h345, cpu_d_o=8'h5A -> mem_addr=16'hA345, cycle_flags=4'h5, halt=0.
REQ-034 Read, mem_ack 3 cycles after mem_req, mem_rdata=8'hC3 -> cpu_d_i=8'hC3, mem_req 1 cycle after strobe, cpu_hold low 1 cycle after ack.
REQ-035 Write cpu_d_o=8'h77, no ack for 15 cycles -> mem_req drops, bus_err one pulse, state returns IDLE after strobe release.
REQ-036 With SCMP_BUSIF_WAIT_EN, cfg_wait=3, immediate ack -> cpu_hold deasserts 4 cycles after ack.
REQ-037 ADS with cpu_d_o[7]=1 -> halt one-cycle pulse; rst_n low during ACCESS -> mem_req=0 immediately, cpu_d_i=8'hFF.
REQ-038 cpu_rd_n and cpu_wr_n low together in ADDR -> mem_we=1 access and bus_err pulse.
